// File: rtl/decode_queue.sv
`default_nettype none
// ============================================================================
// Module   : decode_queue
// Purpose  : Multi-lane instruction decoder feeding a DEPTH-entry FIFO of
//            decoded fetch groups. Each lane of a fetch group is decoded
//            combinationally into rs1/rs2/rd, immediate and EX/MEM/WB
//            control. The whole decoded group is pushed as one FIFO entry.
//            Both sides use valid/ready handshakes, and a flush discards
//            every buffered group.
// Ports    : clk, rst_n (async active-low), flush
//            fetch_valid/fetch_ready, fetch_lane_valid[WIDTH],
//            fetch_inst[32*WIDTH], fetch_pc[32]
//            dec_valid/dec_ready, dec_lane_valid, dec_pc, dec_rs1/rs2/rd,
//            dec_imm, dec_alusrc, dec_branch, dec_jump, dec_memread,
//            dec_memwrite, dec_regwrite, dec_memtoreg, dec_aluop,
//            dec_illegal
// Config   : DECODE_ILLEGAL_TRAP_EN - when defined, flags unsupported
//            opcodes and non-BNE branches in dec_illegal. When undefined,
//            dec_illegal is always 0.
// Revision : 1.0 - initial release
// ============================================================================
module decode_queue #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                fetch_valid,
  output logic                fetch_ready,
  input  logic [WIDTH-1:0]    fetch_lane_valid,
  input  logic [32*WIDTH-1:0] fetch_inst,
  input  logic [31:0]         fetch_pc,
  output logic                dec_valid,
  input  logic                dec_ready,
  output logic [WIDTH-1:0]    dec_lane_valid,
  output logic [32*WIDTH-1:0] dec_pc,
  output logic [5*WIDTH-1:0]  dec_rs1,
  output logic [5*WIDTH-1:0]  dec_rs2,
  output logic [5*WIDTH-1:0]  dec_rd,
  output logic [32*WIDTH-1:0] dec_imm,
  output logic [WIDTH-1:0]    dec_alusrc,
  output logic [WIDTH-1:0]    dec_branch,
  output logic [WIDTH-1:0]    dec_jump,
  output logic [WIDTH-1:0]    dec_memread,
  output logic [WIDTH-1:0]    dec_memwrite,
  output logic [WIDTH-1:0]    dec_regwrite,
  output logic [WIDTH-1:0]    dec_memtoreg,
  output logic [3*WIDTH-1:0]  dec_aluop,
  output logic [WIDTH-1:0]    dec_illegal
);

  localparam int             AW         = $clog2(DEPTH);
  localparam logic [AW:0]    FULL_COUNT = (AW+1)'(DEPTH);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  typedef struct packed {
    logic        lane_valid;
    logic [31:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic        alusrc;
    logic        branch;
    logic        jump;
    logic        memread;
    logic        memwrite;
    logic        regwrite;
    logic        memtoreg;
    logic [2:0]  aluop;
    logic        illegal;
  } lane_t;

  typedef lane_t [WIDTH-1:0] group_t;

  // Decodes one lane. Invalid lanes and unsupported opcodes come out as a
  // NOP: every field zero except ALUOp 111.
  function automatic lane_t decode_lane(input logic v, input logic [31:0] inst,
                                        input logic [31:0] pc);
    lane_t d;
    d       = '0;
    d.aluop = 3'b111;
    if (v) begin
      d.lane_valid = 1'b1;
      d.pc         = pc;
      unique case (inst[6:0])
        OPC_LUI: begin
          d.regwrite = 1'b1;
          d.aluop    = 3'b100;
          d.rd       = inst[11:7];
          d.imm      = {inst[31:12], 12'b0};
        end
        OPC_OPIMM: begin
          d.regwrite = 1'b1;
          d.alusrc   = 1'b1;
          d.aluop    = 3'b010;
          d.rd       = inst[11:7];
          d.rs1      = inst[19:15];
          // ORI zero-extends its immediate; every other OP-IMM sign-extends.
          d.imm      = (inst[14:12] == 3'b110) ? {20'b0, inst[31:20]}
                                               : {{20{inst[31]}}, inst[31:20]};
        end
        OPC_OP: begin
          d.regwrite = 1'b1;
          d.aluop    = 3'b001;
          d.rd       = inst[11:7];
          d.rs1      = inst[19:15];
          d.rs2      = inst[24:20];
        end
        OPC_LOAD: begin
          d.regwrite = 1'b1;
          d.alusrc   = 1'b1;
          d.memread  = 1'b1;
          d.memtoreg = 1'b1;
          d.aluop    = 3'b000;
          d.rd       = inst[11:7];
          d.rs1      = inst[19:15];
          d.imm      = {{20{inst[31]}}, inst[31:20]};
        end
        OPC_STORE: begin
          d.alusrc   = 1'b1;
          d.memwrite = 1'b1;
          d.aluop    = 3'b000;
          d.rs1      = inst[19:15];
          d.rs2      = inst[24:20];
          d.imm      = {{20{inst[31]}}, inst[31:25], inst[11:7]};
        end
        OPC_BRANCH: begin
          d.aluop    = 3'b011;
          d.rs1      = inst[19:15];
          d.rs2      = inst[24:20];
          d.imm      = {{19{inst[31]}}, inst[31], inst[7], inst[30:25],
                        inst[11:8], 1'b0};
          // Only BNE is a supported branch.
          d.branch   = (inst[14:12] == 3'b001);
`ifdef DECODE_ILLEGAL_TRAP_EN
          d.illegal  = (inst[14:12] != 3'b001);
`endif
        end
        OPC_JALR: begin
          d.regwrite = 1'b1;
          d.alusrc   = 1'b1;
          d.jump     = 1'b1;
          d.aluop    = 3'b101;
          d.rd       = inst[11:7];
          d.rs1      = inst[19:15];
          d.imm      = {{20{inst[31]}}, inst[31:20]};
        end
        default: begin
`ifdef DECODE_ILLEGAL_TRAP_EN
          d.illegal  = 1'b1;
`endif
        end
      endcase
    end
    return d;
  endfunction

  group_t          decoded;
  group_t          head;
  group_t          mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     count;
  logic            push;
  logic            pop;

  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_decode
      assign decoded[i] = decode_lane(fetch_lane_valid[i],
                                      fetch_inst[32*i +: 32],
                                      fetch_pc + 32'(4*i));
    end
  endgenerate

  // Handshakes depend only on registered count, so there is no
  // combinational path from dec_ready to fetch_ready.
  assign fetch_ready = (count != FULL_COUNT);
  assign dec_valid   = (count != '0);
  assign push        = fetch_valid & fetch_ready;
  assign pop         = dec_valid & dec_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; entries are only read while count says valid.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= decoded;
  end

  assign head = dec_valid ? mem[rd_ptr] : '0;

  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_out
      assign dec_lane_valid[i]     = head[i].lane_valid;
      assign dec_pc[32*i +: 32]    = head[i].pc;
      assign dec_rs1[5*i +: 5]     = head[i].rs1;
      assign dec_rs2[5*i +: 5]     = head[i].rs2;
      assign dec_rd[5*i +: 5]      = head[i].rd;
      assign dec_imm[32*i +: 32]   = head[i].imm;
      assign dec_alusrc[i]         = head[i].alusrc;
      assign dec_branch[i]         = head[i].branch;
      assign dec_jump[i]           = head[i].jump;
      assign dec_memread[i]        = head[i].memread;
      assign dec_memwrite[i]       = head[i].memwrite;
      assign dec_regwrite[i]       = head[i].regwrite;
      assign dec_memtoreg[i]       = head[i].memtoreg;
      assign dec_aluop[3*i +: 3]   = head[i].aluop;
      assign dec_illegal[i]        = head[i].illegal;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_decode_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_decode_queue
// Purpose  : Directed self-checking bench for decode_queue (WIDTH=2,
//            DEPTH=2). Inputs change and outputs are sampled on the falling
//            clock edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_decode_queue;

  localparam int WIDTH = 2;
  localparam int DEPTH = 2;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                flush;
  logic                fetch_valid;
  logic                fetch_ready;
  logic [WIDTH-1:0]    fetch_lane_valid;
  logic [32*WIDTH-1:0] fetch_inst;
  logic [31:0]         fetch_pc;
  logic                dec_valid;
  logic                dec_ready;
  logic [WIDTH-1:0]    dec_lane_valid;
  logic [32*WIDTH-1:0] dec_pc;
  logic [5*WIDTH-1:0]  dec_rs1, dec_rs2, dec_rd;
  logic [32*WIDTH-1:0] dec_imm;
  logic [WIDTH-1:0]    dec_alusrc, dec_branch, dec_jump, dec_memread;
  logic [WIDTH-1:0]    dec_memwrite, dec_regwrite, dec_memtoreg;
  logic [3*WIDTH-1:0]  dec_aluop;
  logic [WIDTH-1:0]    dec_illegal;

  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  decode_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .fetch_valid(fetch_valid), .fetch_ready(fetch_ready),
    .fetch_lane_valid(fetch_lane_valid), .fetch_inst(fetch_inst),
    .fetch_pc(fetch_pc),
    .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_lane_valid(dec_lane_valid), .dec_pc(dec_pc),
    .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd),
    .dec_imm(dec_imm), .dec_alusrc(dec_alusrc), .dec_branch(dec_branch),
    .dec_jump(dec_jump), .dec_memread(dec_memread),
    .dec_memwrite(dec_memwrite), .dec_regwrite(dec_regwrite),
    .dec_memtoreg(dec_memtoreg), .dec_aluop(dec_aluop),
    .dec_illegal(dec_illegal)
  );

  // ADDI rd, x0, imm -- used to tag groups with a recognisable immediate.
  function automatic logic [31:0] addi(input logic [4:0] rd, input logic [11:0] imm);
    return {imm, 5'd0, 3'b000, rd, 7'b0010011};
  endfunction

  task automatic idle_inputs();
    flush            = 1'b0;
    fetch_valid      = 1'b0;
    fetch_lane_valid = '0;
    fetch_inst       = '0;
    fetch_pc         = '0;
    dec_ready        = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    total++;
    if ({dec_valid, fetch_ready} !== 2'b01) $display("FAIL reset_handshake: got %b want 01", {dec_valid, fetch_ready});
    else passed++;
    total++;
    if ({dec_imm, dec_aluop, dec_lane_valid, dec_regwrite} !== '0) $display("FAIL reset_fields: imm=%h aluop=%b lv=%b", dec_imm, dec_aluop, dec_lane_valid);
    else passed++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_opimm();
    fetch_valid      = 1'b1;
    fetch_lane_valid = 2'b11;
    fetch_inst       = {32'h80006193, 32'hFFF10093};
    fetch_pc         = 32'h0000_1000;
    dec_ready        = 1'b1;
    @(negedge clk);
    fetch_valid = 1'b0;
    total++;
    if (dec_valid !== 1'b1) $display("FAIL opimm_valid: got %b want 1", dec_valid);
    else passed++;
    total++;
    if ({dec_rd[4:0], dec_rs1[4:0], dec_imm[31:0], dec_aluop[2:0]} !== {5'd1, 5'd2, 32'hFFFF_FFFF, 3'b010})
      $display("FAIL opimm_lane0: rd=%0d rs1=%0d imm=%h aluop=%b want 1 2 ffffffff 010", dec_rd[4:0], dec_rs1[4:0], dec_imm[31:0], dec_aluop[2:0]);
    else passed++;
    total++;
    if ({dec_rd[9:5], dec_rs1[9:5], dec_imm[63:32], dec_aluop[5:3]} !== {5'd3, 5'd0, 32'h0000_0800, 3'b010})
      $display("FAIL opimm_lane1: rd=%0d rs1=%0d imm=%h aluop=%b want 3 0 00000800 010", dec_rd[9:5], dec_rs1[9:5], dec_imm[63:32], dec_aluop[5:3]);
    else passed++;
    total++;
    if (dec_pc !== {32'h0000_1004, 32'h0000_1000}) $display("FAIL opimm_pc: got %h want 0000100400001000", dec_pc);
    else passed++;
    total++;
    if ({dec_regwrite, dec_alusrc, dec_memread, dec_lane_valid} !== 8'b11_11_00_11)
      $display("FAIL opimm_ctrl: got %b want 11110011", {dec_regwrite, dec_alusrc, dec_memread, dec_lane_valid});
    else passed++;
    @(negedge clk);
    total++;
    if ({dec_valid, fetch_ready} !== 2'b01) $display("FAIL opimm_drain: got %b want 01", {dec_valid, fetch_ready});
    else passed++;
  endtask

  task automatic test_mem_ops();
    // lane0: lw x5, 4(x6); lane1: sw x7, -4(x8)
    fetch_valid      = 1'b1;
    fetch_lane_valid = 2'b11;
    fetch_inst       = {32'hFE742E23, 32'h00432283};
    fetch_pc         = 32'h0000_2000;
    dec_ready        = 1'b0;
    @(negedge clk);
    fetch_valid = 1'b0;
    total++;
    if ({dec_imm[63:32], dec_imm[31:0]} !== {32'hFFFF_FFFC, 32'h0000_0004})
      $display("FAIL mem_imm: got %h want fffffffc00000004", dec_imm);
    else passed++;
    total++;
    if ({dec_memread, dec_memwrite, dec_regwrite, dec_memtoreg, dec_alusrc, dec_aluop} !== 16'b01_10_01_01_11_000000)
      $display("FAIL mem_ctrl: got %b want 0110010111000000",
               {dec_memread, dec_memwrite, dec_regwrite, dec_memtoreg, dec_alusrc, dec_aluop});
    else passed++;
    total++;
    if ({dec_rd, dec_rs1, dec_rs2} !== {5'd0, 5'd5, 5'd8, 5'd6, 5'd7, 5'd0})
      $display("FAIL mem_regs: rd=%h rs1=%h rs2=%h", dec_rd, dec_rs1, dec_rs2);
    else passed++;
    dec_ready = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_invalid_lane();
    // lane1 invalid although it carries a real LUI; lane0 is FENCE (unsupported)
    fetch_valid      = 1'b1;
    fetch_lane_valid = 2'b01;
    fetch_inst       = {32'h123452B7, 32'h0000000F};
    fetch_pc         = 32'h0000_3000;
    dec_ready        = 1'b0;
    @(negedge clk);
    fetch_valid = 1'b0;
    total++;
    if ({dec_lane_valid, dec_aluop, dec_regwrite} !== {2'b01, 6'b111111, 2'b00})
      $display("FAIL invalid_lane_ctrl: got %b want 0111111100", {dec_lane_valid, dec_aluop, dec_regwrite});
    else passed++;
    total++;
    if ({dec_imm, dec_rd, dec_pc[63:32]} !== '0) $display("FAIL invalid_lane_fields: imm=%h rd=%h pc1=%h", dec_imm, dec_rd, dec_pc[63:32]);
    else passed++;
    total++;
`ifdef DECODE_ILLEGAL_TRAP_EN
    if (dec_illegal !== 2'b01) $display("FAIL invalid_lane_illegal: got %b want 01", dec_illegal);
`else
    if (dec_illegal !== 2'b00) $display("FAIL invalid_lane_illegal: got %b want 00", dec_illegal);
`endif
    else passed++;
    dec_ready = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    fetch_lane_valid = 2'b01;
    fetch_pc         = 32'h0000_4000;
    dec_ready        = 1'b0;
    fetch_valid      = 1'b1;
    fetch_inst       = {32'h0, addi(5'd1, 12'd11)};
    @(negedge clk);
    total++;
    if ({fetch_ready, dec_valid} !== 2'b11) $display("FAIL bp_after1: got %b want 11", {fetch_ready, dec_valid});
    else passed++;
    fetch_inst = {32'h0, addi(5'd1, 12'd22)};
    @(negedge clk);
    total++;
    if (fetch_ready !== 1'b0) $display("FAIL bp_full: got %b want 0", fetch_ready);
    else passed++;
    fetch_inst = {32'h0, addi(5'd1, 12'd33)};
    @(negedge clk);
    total++;
    if ({fetch_ready, dec_imm[31:0]} !== {1'b0, 32'd11}) $display("FAIL bp_hold: ready=%b imm=%0d want 0 11", fetch_ready, dec_imm[31:0]);
    else passed++;
    dec_ready = 1'b1;
    @(negedge clk);
    total++;
    if ({fetch_ready, dec_imm[31:0]} !== {1'b1, 32'd22}) $display("FAIL bp_second: ready=%b imm=%0d want 1 22", fetch_ready, dec_imm[31:0]);
    else passed++;
    @(negedge clk);
    fetch_valid = 1'b0;
    total++;
    if ({dec_valid, dec_imm[31:0]} !== {1'b1, 32'd33}) $display("FAIL bp_third: valid=%b imm=%0d want 1 33", dec_valid, dec_imm[31:0]);
    else passed++;
    @(negedge clk);
    total++;
    if (dec_valid !== 1'b0) $display("FAIL bp_empty: got %b want 0", dec_valid);
    else passed++;
  endtask

  task automatic test_back_to_back();
    fetch_lane_valid = 2'b01;
    fetch_pc         = 32'h0000_5000;
    dec_ready        = 1'b0;
    fetch_valid      = 1'b1;
    fetch_inst       = {32'h0, addi(5'd2, 12'd100)};
    @(negedge clk);
    dec_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      total++;
      if ({dec_valid, fetch_ready, dec_imm[31:0]} !== {2'b11, 32'(100 + k)})
        $display("FAIL b2b_step%0d: valid=%b ready=%b imm=%0d want 1 1 %0d", k, dec_valid, fetch_ready, dec_imm[31:0], 100 + k);
      else passed++;
      fetch_inst = {32'h0, addi(5'd2, 12'(101 + k))};
      @(negedge clk);
    end
    fetch_valid = 1'b0;
    total++;
    if ({dec_valid, dec_imm[31:0]} !== {1'b1, 32'd110}) $display("FAIL b2b_last: valid=%b imm=%0d want 1 110", dec_valid, dec_imm[31:0]);
    else passed++;
    @(negedge clk);
    total++;
    if (dec_valid !== 1'b0) $display("FAIL b2b_empty: got %b want 0", dec_valid);
    else passed++;
  endtask

  task automatic test_flush();
    fetch_lane_valid = 2'b01;
    fetch_pc         = 32'h0000_6000;
    dec_ready        = 1'b0;
    fetch_valid      = 1'b1;
    fetch_inst       = {32'h0, addi(5'd3, 12'd1)};
    repeat (2) @(negedge clk);
    flush      = 1'b1;
    fetch_inst = {32'h0, addi(5'd3, 12'd2)};
    @(negedge clk);
    flush       = 1'b0;
    fetch_valid = 1'b0;
    total++;
    if ({dec_valid, fetch_ready} !== 2'b01) $display("FAIL flush_full: got %b want 01", {dec_valid, fetch_ready});
    else passed++;
    // count = 1, flush together with an accepted push: the push must vanish
    fetch_valid = 1'b1;
    fetch_inst  = {32'h0, addi(5'd3, 12'd3)};
    @(negedge clk);
    flush      = 1'b1;
    fetch_inst = {32'h0, addi(5'd3, 12'd4)};
    @(negedge clk);
    flush       = 1'b0;
    fetch_valid = 1'b0;
    total++;
    if ({dec_valid, fetch_ready, dec_imm[31:0]} !== {2'b01, 32'd0}) $display("FAIL flush_push: valid=%b ready=%b imm=%0d want 0 1 0", dec_valid, fetch_ready, dec_imm[31:0]);
    else passed++;
  endtask

  task automatic test_branch();
    // lane0: beq x1, x2, -8; lane1: bne x1, x2, -8
    fetch_valid      = 1'b1;
    fetch_lane_valid = 2'b11;
    fetch_inst       = {32'hFE209CE3, 32'hFE208CE3};
    fetch_pc         = 32'h0000_7000;
    dec_ready        = 1'b0;
    @(negedge clk);
    fetch_valid = 1'b0;
    total++;
    if (dec_imm !== {32'hFFFF_FFF8, 32'hFFFF_FFF8}) $display("FAIL branch_imm: got %h want fffffff8fffffff8", dec_imm);
    else passed++;
    total++;
    if ({dec_branch, dec_aluop, dec_regwrite, dec_rs1, dec_rs2} !== {2'b10, 6'b011011, 2'b00, 5'd1, 5'd1, 5'd2, 5'd2})
      $display("FAIL branch_ctrl: br=%b aluop=%b rw=%b rs1=%h rs2=%h", dec_branch, dec_aluop, dec_regwrite, dec_rs1, dec_rs2);
    else passed++;
    total++;
`ifdef DECODE_ILLEGAL_TRAP_EN
    if (dec_illegal !== 2'b01) $display("FAIL branch_illegal: got %b want 01", dec_illegal);
`else
    if (dec_illegal !== 2'b00) $display("FAIL branch_illegal: got %b want 00", dec_illegal);
`endif
    else passed++;
    dec_ready = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    fetch_lane_valid = 2'b11;
    fetch_pc         = 32'h0000_8000;
    dec_ready        = 1'b0;
    fetch_valid      = 1'b1;
    fetch_inst       = {addi(5'd4, 12'd7), addi(5'd4, 12'd5)};
    repeat (2) @(negedge clk);
    fetch_valid = 1'b0;
    total++;
    if ({dec_valid, fetch_ready} !== 2'b10) $display("FAIL areset_pre: got %b want 10", {dec_valid, fetch_ready});
    else passed++;
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({dec_valid, fetch_ready} !== 2'b01) $display("FAIL areset_hs: got %b want 01", {dec_valid, fetch_ready});
    else passed++;
    total++;
    if ({dec_imm, dec_pc, dec_rd, dec_lane_valid, dec_regwrite, dec_aluop} !== '0)
      $display("FAIL areset_fields: imm=%h pc=%h rd=%h aluop=%b", dec_imm, dec_pc, dec_rd, dec_aluop);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if ({dec_valid, fetch_ready} !== 2'b01) $display("FAIL areset_post: got %b want 01", {dec_valid, fetch_ready});
    else passed++;
  endtask

  initial begin
    test_reset();
    test_opimm();
    test_mem_ops();
    test_invalid_lane();
    test_backpressure();
    test_back_to_back();
    test_flush();
    test_branch();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got timeout want completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
